pulse_sequencer: RTL and testbench

PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

---
 rtl/pulse_seq_pkg.sv | 35 +++
 rtl/pulse_sequencer_if.sv | 40 ++++
 rtl/pulse_cfg_table.sv | 41 ++++
 rtl/pulse_sequencer.sv | 156 +++++++++++++++
 tb/tb_pulse_sequencer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_seq_pkg.sv
// Shared types for the pulse sequencer: FSM states, config field codes and
// the per-channel parameter record held in the config table.
package pulse_seq_pkg;

    // Width of the channel select carried on o_ch_sel and the config address.
    localparam int CH_W = 2;

    // ST_NEXT names the slot-end decision point. The FSM resolves it in the
    // same edge that ends a slot (straight to SETUP or IDLE), so it is never
    // occupied as a registered state.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SYNC  = 3'd2,
        ST_SLOT  = 3'd3,
        ST_NEXT  = 3'd4
    } state_e;

    // Field codes found in i_cfg_addr[1:0].
    typedef enum logic [1:0] {
        FLD_HIT_LEN     = 2'd0,
        FLD_GND_LEN     = 2'd1,
        FLD_PULSE_COUNT = 2'd2,
        FLD_HUSH_LEN    = 2'd3
    } field_e;

    // One channel's pulse parameters, in output-port order.
    typedef struct packed {
        logic [7:0]  hit_len;
        logic [7:0]  gnd_len;
        logic [3:0]  pulse_count;
        logic [15:0] hush_len;
    } ch_cfg_t;

endpackage

// File: rtl/pulse_sequencer_if.sv
// Control/status bundle between the host side and the pulse sequencer.
interface pulse_sequencer_if #(
    parameter int NCH = 4
);
    import pulse_seq_pkg::*;

    logic            i_run;
    logic [23:0]     i_frame_len;
    logic [15:0]     i_slot_len;
    logic [NCH-1:0]  i_ch_en;
    logic            i_cfg_we;
    logic [3:0]      i_cfg_addr;
    logic [15:0]     i_cfg_data;
    logic            o_sync;
    logic [CH_W-1:0] o_ch_sel;
    logic [7:0]      o_hit_len;
    logic [7:0]      o_gnd_len;
    logic [3:0]      o_pulse_count;
    logic [15:0]     o_hush_len;
    logic            o_busy;
    logic            o_frame_start;
    logic            o_overrun;

    // Host side: drives run/timing/config, observes the sequence.
    modport master (
        output i_run, i_frame_len, i_slot_len, i_ch_en,
        output i_cfg_we, i_cfg_addr, i_cfg_data,
        input  o_sync, o_ch_sel, o_hit_len, o_gnd_len, o_pulse_count,
        input  o_hush_len, o_busy, o_frame_start, o_overrun
    );

    // Sequencer side.
    modport slave (
        input  i_run, i_frame_len, i_slot_len, i_ch_en,
        input  i_cfg_we, i_cfg_addr, i_cfg_data,
        output o_sync, o_ch_sel, o_hit_len, o_gnd_len, o_pulse_count,
        output o_hush_len, o_busy, o_frame_start, o_overrun
    );

endinterface

// File: rtl/pulse_cfg_table.sv
// Per-channel parameter table: NCH entries of four fields, one field-wide
// write port and one whole-entry combinational read port.
module pulse_cfg_table
    import pulse_seq_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic            hi_clk,
    input  logic            rst,
    input  logic            wr_en_i,
    input  logic [CH_W-1:0] wr_ch_i,
    input  field_e          wr_field_i,
    input  logic [15:0]     wr_data_i,
    input  logic [CH_W-1:0] rd_ch_i,
    output ch_cfg_t         rd_data_o
);

    ch_cfg_t tbl_q [NCH];

    // Field write; narrower fields take the LSBs of the write data.
    // NOTE: this storage is reset on purpose -- a channel that was never
    // programmed must drive all-zero parameters, so it cannot be a plain RAM.
    always_ff @(posedge hi_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (wr_en_i && (int'(wr_ch_i) < NCH)) begin
            case (wr_field_i)
                FLD_HIT_LEN:     tbl_q[wr_ch_i].hit_len     <= wr_data_i[7:0];
                FLD_GND_LEN:     tbl_q[wr_ch_i].gnd_len     <= wr_data_i[7:0];
                FLD_PULSE_COUNT: tbl_q[wr_ch_i].pulse_count <= wr_data_i[3:0];
                FLD_HUSH_LEN:    tbl_q[wr_ch_i].hush_len    <= wr_data_i;
                default:         ;
            endcase
        end
    end

    assign rd_data_o = (int'(rd_ch_i) < NCH) ? tbl_q[rd_ch_i] : '0;

endmodule

// File: rtl/pulse_sequencer.sv
// Frame-driven sequencer that time-shares one pulse_channel between NCH
// transducers: each enabled channel gets a slot of SETUP, SYNC and SLOT time.
module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int SYNC_W    = 4,
    parameter int SETUP_CYC = 2
) (
    input logic               hi_clk,
    input logic               rst,
    pulse_sequencer_if.slave  bus
);

    localparam int          MIN_SLOT   = SETUP_CYC + SYNC_W;
    localparam logic [15:0] SYNC_FIRST = 16'(SETUP_CYC);
    localparam logic [15:0] SYNC_LAST  = 16'(MIN_SLOT - 1);

    state_e          state_q;
    logic [23:0]     frame_cnt_q, frame_cnt_d, frame_last;
    logic [15:0]     slot_cnt_q, slot_last;
    logic [CH_W-1:0] ch_q, first_ch, next_ch, launch_ch;
    logic            first_found, next_found;
    logic            tick, idle, slot_end;
    logic            sync_q, busy_q;
    ch_cfg_t         cfg_q, tbl_rd;

    // Frame period and slot length are sampled live and clamped from below.
    // NOTE: every variable assigned in an always_comb gets a value on every
    // path (here unconditionally) so no latch can be inferred.
    always_comb begin
        frame_last = (bus.i_frame_len < 24'd2) ? 24'd1 : bus.i_frame_len - 24'd1;
        slot_last  = (bus.i_slot_len < 16'(MIN_SLOT)) ? SYNC_LAST
                                                      : bus.i_slot_len - 16'd1;
        if (!bus.i_run) begin
            frame_cnt_d = '0;
        end else if (frame_cnt_q >= frame_last) begin
            frame_cnt_d = '0;
        end else begin
            frame_cnt_d = frame_cnt_q + 24'd1;
        end
    end

    // Lowest enabled channel overall and lowest enabled channel above ch_q.
    always_comb begin
        first_found = 1'b0;
        first_ch    = '0;
        next_found  = 1'b0;
        next_ch     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (bus.i_ch_en[i]) begin
                first_found = 1'b1;
                first_ch    = CH_W'(i);
                if (i > int'(ch_q)) begin
                    next_found = 1'b1;
                    next_ch    = CH_W'(i);
                end
            end
        end
    end

    assign idle      = (state_q == ST_IDLE);
    assign tick      = bus.i_run && (frame_cnt_q == '0);
    assign slot_end  = !idle && (slot_cnt_q >= slot_last);
    assign launch_ch = idle ? first_ch : next_ch;

    // Frame counter: held at 0 while stopped, wraps at the frame period.
    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge hi_clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    pulse_cfg_table #(
        .NCH (NCH)
    ) u_cfg_table (
        .hi_clk     (hi_clk),
        .rst        (rst),
        .wr_en_i    (bus.i_cfg_we),
        .wr_ch_i    (bus.i_cfg_addr[3:2]),
        .wr_field_i (field_e'(bus.i_cfg_addr[1:0])),
        .wr_data_i  (bus.i_cfg_data),
        .rd_ch_i    (launch_ch),
        .rd_data_o  (tbl_rd)
    );

    // Sequencing FSM; the slot counter runs from the first SETUP cycle and
    // the slot-end decision goes straight to the next SETUP or to IDLE.
    always_ff @(posedge hi_clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            slot_cnt_q <= '0;
            ch_q       <= '0;
            sync_q     <= 1'b0;
            busy_q     <= 1'b0;
            cfg_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick && first_found) begin
                        state_q    <= ST_SETUP;
                        slot_cnt_q <= '0;
                        ch_q       <= first_ch;
                        cfg_q      <= tbl_rd;
                        busy_q     <= 1'b1;
                    end
                end
                ST_SETUP, ST_SYNC, ST_SLOT: begin
                    if (slot_end) begin
                        sync_q     <= 1'b0;
                        slot_cnt_q <= '0;
                        if (next_found) begin
                            state_q <= ST_SETUP;
                            ch_q    <= next_ch;
                            cfg_q   <= tbl_rd;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        slot_cnt_q <= slot_cnt_q + 16'd1;
                        if (state_q == ST_SETUP && slot_cnt_q == SYNC_FIRST - 16'd1) begin
                            state_q <= ST_SYNC;
                            sync_q  <= 1'b1;
                        end
                        if (state_q == ST_SYNC && slot_cnt_q == SYNC_LAST) begin
                            state_q <= ST_SLOT;
                            sync_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    sync_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_sync        = sync_q;
    assign bus.o_ch_sel      = ch_q;
    assign bus.o_hit_len     = cfg_q.hit_len;
    assign bus.o_gnd_len     = cfg_q.gnd_len;
    assign bus.o_pulse_count = cfg_q.pulse_count;
    assign bus.o_hush_len    = cfg_q.hush_len;
    assign bus.o_busy        = busy_q;
    // Tick-coincident pulses, forced low while reset is asserted.
    assign bus.o_frame_start = !rst && tick && idle;
    assign bus.o_overrun     = !rst && tick && !idle;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboard bench for pulse_sequencer: each scenario computes the expected
// event timeline (frame starts, overruns, sync rises with channel parameters,
// busy falls) from frame/slot arithmetic; a negedge monitor compares.
module tb_pulse_sequencer;
    import pulse_seq_pkg::*;

    localparam int NCH       = 4;
    localparam int SYNC_W    = 4;
    localparam int SETUP_CYC = 2;
    localparam int MIN_SLOT  = SETUP_CYC + SYNC_W;

    localparam logic [3:0] K_FS   = 4'd0;
    localparam logic [3:0] K_OVR  = 4'd1;
    localparam logic [3:0] K_SYNC = 4'd2;
    localparam logic [3:0] K_BF   = 4'd3;

    typedef struct packed {
        int          cyc;
        logic [3:0]  kind;
        logic [3:0]  ch;
        logic [35:0] prm;
    } ev_t;

    typedef struct {
        int          cyc;
        int          ch;
        int          fld;
        logic [15:0] data;
    } wr_t;

    logic hi_clk = 1'b0;
    logic rst    = 1'b1;
    int   cyc    = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    ev_t  exp_q [$];
    wr_t  wr_log [$];
    logic prev_sync = 1'b0;
    logic prev_busy = 1'b0;

    pulse_sequencer_if #(.NCH(NCH)) bus ();

    pulse_sequencer #(
        .NCH       (NCH),
        .SYNC_W    (SYNC_W),
        .SETUP_CYC (SETUP_CYC)
    ) dut (
        .hi_clk (hi_clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 hi_clk = ~hi_clk;
    always @(posedge hi_clk) cyc++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    function automatic longint ev_key(ev_t e);
        return longint'(e.cyc) * 4 + longint'(e.kind);
    endfunction

    // Keep the expected queue ordered by cycle, then by monitor order.
    task automatic push_ev(ev_t e);
        int pos = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (ev_key(exp_q[i]) > ev_key(e)) begin
                pos = i;
                break;
            end
        end
        exp_q.insert(pos, e);
    endtask

    // Table contents as seen by a slot whose first SETUP cycle is s: the
    // entry is latched at the edge starting s, so writes issued up to s-2.
    function automatic logic [35:0] cfg_at(int ch, int s);
        logic [7:0]  h  = '0;
        logic [7:0]  g  = '0;
        logic [3:0]  c  = '0;
        logic [15:0] hu = '0;
        foreach (wr_log[i]) begin
            if (wr_log[i].cyc <= s - 2 && wr_log[i].ch == ch) begin
                case (wr_log[i].fld)
                    0:       h  = wr_log[i].data[7:0];
                    1:       g  = wr_log[i].data[7:0];
                    2:       c  = wr_log[i].data[3:0];
                    default: hu = wr_log[i].data;
                endcase
            end
        end
        return {h, g, c, hu};
    endfunction

    // Reference timeline: ticks every max(F,2) cycles while run is high; a
    // tick on an idle sequencer starts a frame of popcount(mask) slots of
    // max(S, SETUP_CYC+SYNC_W) cycles each, a tick while busy is an overrun.
    task automatic build_model(int t0, int f, int s, logic [3:0] mask, int run_cycles);
        int fe = (f < 2) ? 2 : f;
        int se = (s < MIN_SLOT) ? MIN_SLOT : s;
        int n = 0;
        int busy_until = t0;
        for (int c = 0; c < NCH; c++) if (mask[c]) n++;
        for (int t = t0; t < t0 + run_cycles; t += fe) begin
            if (t < busy_until) begin
                push_ev('{t, K_OVR, 4'd0, 36'd0});
            end else begin
                push_ev('{t, K_FS, 4'd0, 36'd0});
                if (n > 0) begin
                    int k = 0;
                    for (int c = 0; c < NCH; c++) begin
                        if (mask[c]) begin
                            int st = t + 1 + k * se;
                            push_ev('{st + SETUP_CYC, K_SYNC, 4'(c), cfg_at(c, st)});
                            k++;
                        end
                    end
                    busy_until = t + 1 + n * se;
                    push_ev('{busy_until, K_BF, 4'd0, 36'd0});
                end
            end
        end
    endtask

    task automatic observe(logic [3:0] kind, logic [3:0] ch, logic [35:0] prm);
        ev_t o = '{cyc, kind, ch, prm};
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected event kind %0d @cycle %0d: got ch %0d prm %0h, required none",
                     kind, cyc, ch, prm);
        end else begin
            ev_t e = exp_q.pop_front();
            check($sformatf("event kind %0d (cyc,kind,ch,prm)", e.kind), 128'(o), 128'(e));
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge hi_clk) begin
        if (rst) begin
            prev_sync = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (bus.o_frame_start) observe(K_FS, 4'd0, 36'd0);
            if (bus.o_overrun)     observe(K_OVR, 4'd0, 36'd0);
            if (bus.o_sync && !prev_sync)
                observe(K_SYNC, 4'(bus.o_ch_sel),
                        {bus.o_hit_len, bus.o_gnd_len, bus.o_pulse_count, bus.o_hush_len});
            if (!bus.o_busy && prev_busy) observe(K_BF, 4'd0, 36'd0);
            prev_sync = bus.o_sync;
            prev_busy = bus.o_busy;
        end
    end

    function automatic logic [127:0] out_vec();
        return 128'({bus.o_sync, bus.o_ch_sel, bus.o_hit_len, bus.o_gnd_len,
                     bus.o_pulse_count, bus.o_hush_len, bus.o_busy,
                     bus.o_frame_start, bus.o_overrun});
    endfunction

    // Every expected event earlier than 'limit' is overdue and counts as missed.
    task automatic drain_missing(int limit);
        while (exp_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            if (e.cyc < limit) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing event kind %0d: got nothing, required it @cycle %0d ch %0d",
                         e.kind, e.cyc, e.ch);
            end
        end
    endtask

    // Reset with run held high, so the tick-derived pulses must stay gated.
    task automatic do_reset();
        rst = 1'b1;
        bus.i_run = 1'b1;
        bus.i_cfg_we = 1'b0;
        repeat (2) @(posedge hi_clk);
        #1;
        check("outputs during reset", out_vec(), '0);
        bus.i_run = 1'b0;
        rst = 1'b0;
        wr_log.delete();
    endtask

    task automatic cfg_write(int ch, int fld, logic [15:0] data);
        bus.i_cfg_we   = 1'b1;
        bus.i_cfg_addr = {2'(ch), 2'(fld)};
        bus.i_cfg_data = data;
        wr_log.push_back('{cyc, ch, fld, data});
        @(posedge hi_clk);
        #1;
        bus.i_cfg_we = 1'b0;
    endtask

    task automatic run_scn(int f, int s, logic [3:0] mask, int run_cycles,
                           int wr_off, int wr_ch, int wr_fld, logic [15:0] wr_data,
                           int abort_off);
        int t0;
        int w;
        int bound;
        do_reset();
        for (int c = 0; c < NCH; c++)
            for (int fl = 0; fl < 4; fl++)
                cfg_write(c, fl, 16'($urandom));
        bus.i_frame_len = 24'(f);
        bus.i_slot_len  = 16'(s);
        bus.i_ch_en     = mask;
        @(posedge hi_clk);
        #1;
        t0 = cyc;
        if (wr_off >= 0) wr_log.push_back('{t0 + wr_off, wr_ch, wr_fld, wr_data});
        build_model(t0, f, s, mask, run_cycles);
        bus.i_run = 1'b1;
        for (int k = 0; k < run_cycles; k++) begin
            if (k == abort_off) begin
                rst = 1'b1;
                #1;
                check("outputs right after mid-sequence reset", out_vec(), '0);
                drain_missing(cyc);
                bus.i_run = 1'b0;
                bus.i_cfg_we = 1'b0;
                repeat (2) @(posedge hi_clk);
                #1;
                rst = 1'b0;
                return;
            end
            if (k == wr_off) begin
                bus.i_cfg_we   = 1'b1;
                bus.i_cfg_addr = {2'(wr_ch), 2'(wr_fld)};
                bus.i_cfg_data = wr_data;
            end else begin
                bus.i_cfg_we = 1'b0;
            end
            @(posedge hi_clk);
            #1;
        end
        bus.i_run = 1'b0;
        bus.i_cfg_we = 1'b0;
        bound = NCH * ((s < MIN_SLOT) ? MIN_SLOT : s) + 10;
        w = 0;
        while (bus.o_busy && w < bound) begin
            @(posedge hi_clk);
            #1;
            w++;
        end
        check("sequence finished after run fell (busy)", 128'(bus.o_busy), 128'(0));
        repeat (2) @(posedge hi_clk);
        #1;
        drain_missing(cyc + 1);
    endtask

    initial begin
        bus.i_run = 1'b0;
        bus.i_frame_len = '0;
        bus.i_slot_len = '0;
        bus.i_ch_en = '0;
        bus.i_cfg_we = 1'b0;
        bus.i_cfg_addr = '0;
        bus.i_cfg_data = '0;

        // Two frames of channels 0 and 2, 100-cycle slots, 1000-cycle period.
        run_scn(1000, 100, 4'b0101, 1001, -1, 0, 0, 16'h0, -1);
        // Slot shorter than SETUP+SYNC is stretched to 6 cycles.
        run_scn(100, 3, 4'hF, 50, -1, 0, 0, 16'h0, -1);
        // Frame shorter than the sequence: ticks while busy are overruns.
        run_scn(150, 100, 4'hF, 301, -1, 0, 0, 16'h0, -1);
        // hit_len written during channel 1's SYNC only shows next frame.
        run_scn(300, 50, 4'hF, 301, 54, 1, 0, 16'h0020, -1);
        // Reset during channel 2's SYNC, then a fresh run restarts at ch 0.
        run_scn(1000, 40, 4'hF, 200, -1, 0, 0, 16'h0, 84);
        run_scn(1000, 40, 4'hF, 100, -1, 0, 0, 16'h0, -1);
        // Empty mask: frame starts only; period below 2 clamps to 2.
        run_scn(1, 10, 4'b0000, 7, -1, 0, 0, 16'h0, -1);
        // Randomised timing and masks.
        for (int r = 0; r < 6; r++) begin
            run_scn(int'($urandom_range(0, 300)), int'($urandom_range(0, 90)),
                    4'($urandom_range(0, 15)), int'($urandom_range(1, 500)),
                    -1, 0, 0, 16'h0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
